// File: rtl/wb_grf.sv
// Write-back stage and 32-entry general register file for the 5-stage MIPS
// pipeline. Chooses the write-back value from the MEM/WB register, commits it
// to the register array one edge later, and serves the two ID-stage read
// ports. A write and a read of the same register in one cycle return the new
// value through a bypass. Register 0 always reads as zero.
module wb_grf #(
  parameter int DW          = 32,
  parameter int NREG        = 32,
  parameter int PC_LINK_OFS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] wb_dm_data,
  input  logic [DW-1:0] wb_alu_out,
  input  logic [4:0]    wb_waddr,
  input  logic [DW-1:0] wb_pc,
  input  logic [1:0]    wb_mem_to_reg,
  input  logic [4:0]    rs_addr,
  input  logic [4:0]    rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] wb_wdata,
  output logic          wb_we
);

  logic [DW-1:0] regs [NREG];

  // Write-back source mux; the link address wraps silently at 2^DW and the
  // reserved encoding drives zero.
  function automatic logic [DW-1:0] wb_select(input logic [1:0]    sel,
                                              input logic [DW-1:0] alu,
                                              input logic [DW-1:0] dm,
                                              input logic [DW-1:0] pc);
    logic [DW-1:0] res;
    case (sel)
      2'd0:    res = alu;
      2'd1:    res = dm;
      2'd2:    res = pc + DW'(PC_LINK_OFS);
      default: res = '0;
    endcase
    return res;
  endfunction

  // Select the write-back value; upstream encodes "no write" as address 0.
  always_comb begin
    wb_wdata = wb_select(wb_mem_to_reg, wb_alu_out, wb_dm_data, wb_pc);
    wb_we    = (wb_waddr != 5'd0);
  end

  // Read port A: r0 is zero, a same-cycle write wins, otherwise the array.
  always_comb begin
    rs_data = '0;
    if (rs_addr == 5'd0) begin
      rs_data = '0;
    end else if (wb_we && (rs_addr == wb_waddr)) begin
      rs_data = wb_wdata;
    end else if (int'(rs_addr) < NREG) begin
      rs_data = regs[rs_addr];
    end
  end

  // Read port B: same priority as port A.
  always_comb begin
    rt_data = '0;
    if (rt_addr == 5'd0) begin
      rt_data = '0;
    end else if (wb_we && (rt_addr == wb_waddr)) begin
      rt_data = wb_wdata;
    end else if (int'(rt_addr) < NREG) begin
      rt_data = regs[rt_addr];
    end
  end

  // Register array: reset clears everything at once, a write pending while
  // reset is high is dropped; r0 is never written because wb_we excludes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && (int'(wb_waddr) < NREG)) begin
      regs[wb_waddr] <= wb_wdata;
    end
  end

endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: expectations are queued as stimulus is applied
// and drained against the DUT outputs once they have settled.
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic [31:0] wb_dm_data;
  logic [31:0] wb_alu_out;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_pc;
  logic [1:0]  wb_mem_to_reg;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_wdata;
  logic        wb_we;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          sig;   // 0 rs_data, 1 rt_data, 2 wb_wdata, 3 wb_we
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  wb_grf #(.DW(32), .NREG(32), .PC_LINK_OFS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_dm_data    (wb_dm_data),
    .wb_alu_out    (wb_alu_out),
    .wb_waddr      (wb_waddr),
    .wb_pc         (wb_pc),
    .wb_mem_to_reg (wb_mem_to_reg),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .wb_wdata      (wb_wdata),
    .wb_we         (wb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input int sig, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sig = sig;
    x.exp = e;
    sb.push_back(x);
  endtask

  // Let combinational outputs settle, then compare every queued expectation.
  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sig)
        0:       obs = rs_data;
        1:       obs = rt_data;
        2:       obs = wb_wdata;
        default: obs = {31'b0, wb_we};
      endcase
      checks++;
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] dm, input logic [31:0] pc,
                          input logic [4:0] wa);
    wb_mem_to_reg = sel;
    wb_alu_out    = alu;
    wb_dm_data    = dm;
    wb_pc         = pc;
    wb_waddr      = wa;
  endtask

  function automatic logic [31:0] fill_pat(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hA500_0000;
  endfunction

  initial begin
    reset   = 1'b1;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    drive_wb(2'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    push("rst_rs", 0, 32'h0);
    push("rst_rt", 1, 32'h0);
    push("rst_we", 3, 32'h0);
    drain();

    // 1: r5 written, then cleared by an asynchronous reset with no edge
    drive_wb(2'd0, 32'h0000_1234, 32'h0, 32'h0, 5'd5);
    step();
    wb_waddr = 5'd0;
    push("r5_written", 0, 32'h0000_1234);
    drain();
    reset = 1'b1;
    push("r5_async_clear", 0, 32'h0);
    drain();
    reset = 1'b0;
    step();
    for (int i = 1; i < 32; i++) begin
      drive_wb(2'd0, fill_pat(i), 32'h0, 32'h0, 5'(i));
      step();
    end
    wb_waddr = 5'd0;
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(32 - i);
      push($sformatf("fill_rs_r%0d", i), 0, fill_pat(i));
      push($sformatf("fill_rt_r%0d", 32 - i), 1, fill_pat(32 - i));
      drain();
    end
    reset = 1'b1;
    #2;
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(i);
      push($sformatf("clr_rs_r%0d", i), 0, 32'h0);
      push($sformatf("clr_rt_r%0d", i), 1, 32'h0);
      drain();
    end
    step();

    // 2: same-cycle bypass, then value from the array
    drive_wb(2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd8);
    rs_addr = 5'd8;
    rt_addr = 5'd0;
    push("byp_rs", 0, 32'hDEAD_BEEF);
    push("byp_we", 3, 32'h1);
    push("byp_rt_r0", 1, 32'h0);
    drain();
    step();
    wb_waddr = 5'd0;
    push("arr_r8", 0, 32'hDEAD_BEEF);
    drain();

    // 3: load data, link address and link wrap into r31
    rs_addr = 5'd31;
    drive_wb(2'd1, 32'h0, 32'h0000_00FF, 32'h0, 5'd31);
    push("dm_wdata", 2, 32'h0000_00FF);
    drain();
    step();
    wb_waddr = 5'd0;
    push("dm_r31", 0, 32'h0000_00FF);
    drain();
    drive_wb(2'd2, 32'h0, 32'h0, 32'h0000_3000, 5'd31);
    push("link_wdata", 2, 32'h0000_3008);
    drain();
    step();
    wb_waddr = 5'd0;
    push("link_r31", 0, 32'h0000_3008);
    drain();
    drive_wb(2'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd31);
    push("wrap_wdata", 2, 32'h0000_0004);
    drain();
    step();
    wb_waddr = 5'd0;
    push("wrap_r31", 0, 32'h0000_0004);
    drain();

    // 4: address 0 never writes and always reads zero
    drive_wb(2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    push("r0_we", 3, 32'h0);
    push("r0_rs_pre", 0, 32'h0);
    push("r0_rt_pre", 1, 32'h0);
    drain();
    step();
    push("r0_rs_post", 0, 32'h0);
    push("r0_rt_post", 1, 32'h0);
    drain();

    // 5: reserved select overwrites a nonzero r4 with zero
    drive_wb(2'd0, 32'h0000_0077, 32'h0, 32'h0, 5'd4);
    step();
    wb_waddr = 5'd0;
    rs_addr  = 5'd4;
    push("r4_pre", 0, 32'h0000_0077);
    drain();
    drive_wb(2'd3, 32'h0000_0055, 32'h0000_0066, 32'h0000_1000, 5'd4);
    push("rsv_wdata", 2, 32'h0);
    push("rsv_we", 3, 32'h1);
    drain();
    step();
    wb_waddr = 5'd0;
    push("rsv_r4", 0, 32'h0);
    drain();

    // 6: back-to-back writes to r9, then a write dropped by reset
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    drive_wb(2'd0, 32'h0000_000A, 32'h0, 32'h0, 5'd9);
    push("b2b_rs_a", 0, 32'h0000_000A);
    push("b2b_rt_a", 1, 32'h0000_000A);
    drain();
    step();
    wb_waddr = 5'd0;
    push("b2b_arr_a", 0, 32'h0000_000A);
    drain();
    drive_wb(2'd0, 32'h0000_000B, 32'h0, 32'h0, 5'd9);
    push("b2b_rs_b", 0, 32'h0000_000B);
    push("b2b_rt_b", 1, 32'h0000_000B);
    drain();
    step();
    wb_waddr = 5'd0;
    push("b2b_arr_rs_b", 0, 32'h0000_000B);
    push("b2b_arr_rt_b", 1, 32'h0000_000B);
    drain();
    drive_wb(2'd0, 32'h0000_000C, 32'h0, 32'h0, 5'd9);
    reset = 1'b1;
    push("rstw_wdata", 2, 32'h0000_000C);
    push("rstw_we", 3, 32'h1);
    push("rstw_rs_byp", 0, 32'h0000_000C);
    drain();
    step();
    reset    = 1'b0;
    wb_waddr = 5'd0;
    push("rstw_rs_r9", 0, 32'h0);
    push("rstw_rt_r9", 1, 32'h0);
    drain();
    drive_wb(2'd0, 32'h0000_000D, 32'h0, 32'h0, 5'd9);
    step();
    wb_waddr = 5'd0;
    push("post_rst_r9", 0, 32'h0000_000D);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
